containment_light_driver: RTL and testbench
===========================================

// Module: containment_light_driver
// PURPOSE
//  Facility-side counterpart of the SCP-079 containment FSM. It drives the FSM's
//  green/yellow/red light inputs and watches its attack outputs (a1/a2/a3/cheat_out).
//  It pushes the AI back with timed yellow and red phases, and detects lockdown and breach.
//  Time is counted in clock cycles; no free-running delay timers.
// PARAMETERS
//  CW          8   width of dwell counter
//  ALERT_CYC   20  cycles a1 may stay high in GREEN before a yellow push-back
//  YELLOW_CYC  5   cycles yellow is held per push-back
//  CHEAT_HOLD  15  cycles red is held after cheat_out rises before lockdown decision
// PORTS
//  clock        in   1   rising-edge clock
//  reset_n      in   1   synchronous active-low reset
//  enable       in   1   start/continue light sequencing
//  a1,a2,a3     in   1   attack security/database/control outputs of the AI FSM
//  cheat_out    in   1   cheat output of the AI FSM
//  green        out  1   light to AI FSM (advance permitted)
//  yellow       out  1   light to AI FSM (push back one stage)
//  red          out  1   light to AI FSM (alarm)
//  lockdown     out  1   sticky: cheat persisted through CHEAT_HOLD
//  breach       out  1   sticky: a3 observed high
//  state        out  3   current state encoding
//  dwell        out  CW  cycles in current state, saturating
//  attempts     out  4   count of a1 rising edges, saturating at 15
// BEHAVIOUR
//  - Single clock. Reset is synchronous: reset_n low at a rising edge puts all outputs at 0
//    and the state at IDLE. Reset overrides everything, including an operation in progress.
//  - All outputs are registered. The response to input values sampled at edge k is visible
//    after edge k. {green,yellow,red} is one-hot in GREEN/YELLOW/RED and 000 otherwise.
//  - Edge detect: rise_x = x & ~x_q, where x_q is x registered at the previous edge
//    (x_q = 0 after reset).
//  - States: IDLE=000, GREEN=001, YELLOW=010, RED=011, LOCK=100, BREACH=101.
//  - Transition priority at every edge, highest first:
//    1. a3 high (any non-IDLE state) -> BREACH.
//    2. rise of cheat_out -> RED.
//    3. rise of a2 -> RED.
//    4. the state-local rules below.
//  - IDLE: go to GREEN when enable=1. Stay in IDLE while enable=0.
//  - GREEN: if a1=1 and dwell = ALERT_CYC-1, go to YELLOW.
//           If enable=0, go to IDLE.
//  - YELLOW: go to GREEN when dwell = YELLOW_CYC-1. A fall of a1 also returns to GREEN.
//  - RED, entered by cheat: at dwell = CHEAT_HOLD-1:
//      cheat_out=1 -> LOCK;
//      cheat_out=0 -> GREEN.
//    A fall of cheat_out before that point returns to GREEN immediately.
//  - RED, entered by a2 only: go to GREEN when a2 falls. A later rise of cheat_out restarts
//    RED in cheat mode with dwell=0. Use an internal 1-bit flag for the red mode.
//  - LOCK, BREACH: terminal until reset. Lights are 000.
//    lockdown=1 in LOCK; breach=1 in BREACH; each stays 1 until reset.
//  - enable=0 has no effect in RED, LOCK or BREACH.
//  - dwell: 0 on the edge that changes state, +1 otherwise, saturates at 2^CW-1
//    (no wrap-around).
//  - attempts: +1 on each rise_a1 in any state except IDLE; holds at 15.
//  - Simultaneous rise_cheat and rise_a2: cheat mode wins.
//    a3 together with any other event: BREACH wins.
// TESTING
//  - Reset: hold reset_n=0 for 3 clocks with all inputs at 1 -> all outputs 0, state=000.
//  - Yellow push-back: enable=1, a1=1 held -> GREEN, then YELLOW after 20 cycles.
//    yellow high for 5 cycles, then back to green=1. attempts=1.
//  - Cheat lockdown: cheat_out rises in GREEN and is held 15 cycles -> red=1 for 15 cycles,
//    then state=100, lockdown=1, lights 000. Further inputs are ignored.
//  - Cheat recovery: cheat_out pulses high for 4 cycles -> red for 4 cycles, then GREEN
//    with dwell=0. lockdown stays 0.
//  - Breach priority: a3, a2 and cheat_out all rise on the same edge -> state=101, breach=1,
//    lights 000. Still 101 after 300 cycles with dwell=255 (saturated).
//  - Reset mid-RED: reset_n=0 at dwell=7 -> IDLE, dwell=0, lights 000.
//    Re-enable -> GREEN after 1 clock.

Source files
------------

// File: rtl/containment_light_driver_if.sv
// Signal bundle between the facility light driver and the SCP-079 containment FSM.
// The master end drives the AI-side outputs and watches the lights; the slave end is the driver.
interface containment_light_driver_if #(
  parameter int CW = 8
);
  logic          enable;
  logic          a1;
  logic          a2;
  logic          a3;
  logic          cheat_out;
  logic          green;
  logic          yellow;
  logic          red;
  logic          lockdown;
  logic          breach;
  logic [2:0]    state;
  logic [CW-1:0] dwell;
  logic [3:0]    attempts;

  modport master (
    output enable, a1, a2, a3, cheat_out,
    input  green, yellow, red, lockdown, breach, state, dwell, attempts
  );

  modport slave (
    input  enable, a1, a2, a3, cheat_out,
    output green, yellow, red, lockdown, breach, state, dwell, attempts
  );
endinterface

// File: rtl/containment_light_driver.sv
// Facility-side light sequencer for the SCP-079 containment FSM: pushes the AI back with
// timed yellow/red phases and latches lockdown or breach. All outputs are registered.
//
// state  | meaning
// IDLE   | sequencing disabled, lights off
// GREEN  | AI may advance; watches a1 dwell
// YELLOW | push-back phase, YELLOW_CYC cycles
// RED    | alarm; cheat mode (timed hold) or a2 mode (until a2 falls)
// LOCK   | cheat persisted, terminal until reset
// BREACH | a3 seen, terminal until reset
module containment_light_driver #(
  parameter int CW         = 8,
  parameter int ALERT_CYC  = 20,
  parameter int YELLOW_CYC = 5,
  parameter int CHEAT_HOLD = 15
) (
  input logic                     clock,
  input logic                     reset_n,
  containment_light_driver_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_GREEN  = 3'b001,
    S_YELLOW = 3'b010,
    S_RED    = 3'b011,
    S_LOCK   = 3'b100,
    S_BREACH = 3'b101
  } state_t;

  localparam logic [CW-1:0] DWELL_MAX   = '1;
  localparam logic [CW-1:0] ALERT_LAST  = CW'(ALERT_CYC - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] CHEAT_LAST  = CW'(CHEAT_HOLD - 1);

  state_t        state_q, state_d;
  logic          red_cheat_q, red_cheat_d;
  logic          restart;
  logic          a1_q, a2_q, cheat_q;
  logic [2:0]    light_q, light_d;
  logic          lockdown_q, lockdown_d;
  logic          breach_q, breach_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [3:0]    attempts_q, attempts_d;

  logic rise_a1, rise_a2, fall_a1, fall_a2, rise_cheat, fall_cheat;

  assign rise_a1    = bus.a1 & ~a1_q;
  assign fall_a1    = ~bus.a1 & a1_q;
  assign rise_a2    = bus.a2 & ~a2_q;
  assign fall_a2    = ~bus.a2 & a2_q;
  assign rise_cheat = bus.cheat_out & ~cheat_q;
  assign fall_cheat = ~bus.cheat_out & cheat_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      red_cheat_q <= 1'b0;
      a1_q        <= 1'b0;
      a2_q        <= 1'b0;
      cheat_q     <= 1'b0;
      light_q     <= 3'b000;
      lockdown_q  <= 1'b0;
      breach_q    <= 1'b0;
      dwell_q     <= '0;
      attempts_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      red_cheat_q <= red_cheat_d;
      a1_q        <= bus.a1;
      a2_q        <= bus.a2;
      cheat_q     <= bus.cheat_out;
      light_q     <= light_d;
      lockdown_q  <= lockdown_d;
      breach_q    <= breach_d;
      dwell_q     <= dwell_d;
      attempts_q  <= attempts_d;
    end
  end

  // restart marks a (re)entry into RED that must clear dwell even without a state change
  always_comb begin
    state_d     = state_q;
    red_cheat_d = red_cheat_q;
    restart     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_GREEN;
      end
      S_LOCK, S_BREACH: begin
        state_d = state_q;
      end
      default: begin
        if (bus.a3) begin
          state_d = S_BREACH;
        end else if (rise_cheat) begin
          state_d     = S_RED;
          red_cheat_d = 1'b1;
          restart     = 1'b1;
        end else if (rise_a2 && state_q != S_RED) begin
          state_d     = S_RED;
          red_cheat_d = 1'b0;
          restart     = 1'b1;
        end else begin
          case (state_q)
            S_GREEN: begin
              if (bus.a1 && dwell_q == ALERT_LAST) state_d = S_YELLOW;
              else if (!bus.enable)                state_d = S_IDLE;
            end
            S_YELLOW: begin
              if (dwell_q == YELLOW_LAST || fall_a1) state_d = S_GREEN;
            end
            S_RED: begin
              if (red_cheat_q) begin
                if (fall_cheat)                state_d = S_GREEN;
                else if (dwell_q == CHEAT_LAST) state_d = bus.cheat_out ? S_LOCK : S_GREEN;
              end else if (fall_a2) begin
                state_d = S_GREEN;
              end
            end
            default: state_d = state_q;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    light_d = 3'b000;
    case (state_d)
      S_GREEN:  light_d = 3'b100;
      S_YELLOW: light_d = 3'b010;
      S_RED:    light_d = 3'b001;
      default:  light_d = 3'b000;
    endcase
    lockdown_d = (state_d == S_LOCK);
    breach_d   = (state_d == S_BREACH);

    if (state_d != state_q || restart) dwell_d = '0;
    else if (dwell_q != DWELL_MAX)     dwell_d = dwell_q + CW'(1);
    else                               dwell_d = dwell_q;

    attempts_d = attempts_q;
    if (state_q != S_IDLE && rise_a1 && attempts_q != 4'hF) attempts_d = attempts_q + 4'd1;
  end

  assign bus.green    = light_q[2];
  assign bus.yellow   = light_q[1];
  assign bus.red      = light_q[0];
  assign bus.lockdown = lockdown_q;
  assign bus.breach   = breach_q;
  assign bus.state    = state_q;
  assign bus.dwell    = dwell_q;
  assign bus.attempts = attempts_q;

endmodule

// File: tb/tb_containment_light_driver.sv
// Directed bench for containment_light_driver; status vector is {state, g, y, r, lockdown, breach}.
module tb_containment_light_driver;
  logic clock;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  containment_light_driver_if #(.CW(8)) bus ();

  containment_light_driver #(
    .CW(8), .ALERT_CYC(20), .YELLOW_CYC(5), .CHEAT_HOLD(15)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] status();
    return {bus.state, bus.green, bus.yellow, bus.red, bus.lockdown, bus.breach};
  endfunction

  task automatic set_inputs(input logic en, input logic x1, input logic x2,
                            input logic x3, input logic ch);
    bus.enable = en; bus.a1 = x1; bus.a2 = x2; bus.a3 = x3; bus.cheat_out = ch;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_inputs(1, 1, 1, 1, 1);
    repeat (3) tick();
    total++; if (status() !== 8'h00) begin bad++; $display("FAIL reset_status got=%b exp=%b", status(), 8'h00); end
    total++; if (bus.dwell !== 8'd0) begin bad++; $display("FAIL reset_dwell got=%0d exp=0", bus.dwell); end
    total++; if (bus.attempts !== 4'd0) begin bad++; $display("FAIL reset_attempts got=%0d exp=0", bus.attempts); end
    set_inputs(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();
    total++; if (status() !== 8'h00 || bus.dwell !== 8'd1) begin bad++; $display("FAIL idle_hold got=%b/%0d exp=%b/1", status(), bus.dwell, 8'h00); end
  endtask

  task automatic test_yellow();
    bus.enable = 1'b1;
    tick();
    total++; if (status() !== 8'b001_100_00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL enter_green got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b001_100_00); end
    bus.a1 = 1'b1;
    tick();
    total++; if (bus.attempts !== 4'd1 || bus.dwell !== 8'd1) begin bad++; $display("FAIL a1_rise got=%0d/%0d exp=1/1", bus.attempts, bus.dwell); end
    for (int i = 2; i <= 19; i++) begin
      tick();
      total++; if (status() !== 8'b001_100_00) begin bad++; $display("FAIL green_dwell%0d got=%b exp=%b", i, status(), 8'b001_100_00); end
    end
    total++; if (bus.dwell !== 8'd19) begin bad++; $display("FAIL green_last got=%0d exp=19", bus.dwell); end
    tick();
    total++; if (status() !== 8'b010_010_00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL enter_yellow got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b010_010_00); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (status() !== 8'b010_010_00) begin bad++; $display("FAIL yellow_hold%0d got=%b exp=%b", i, status(), 8'b010_010_00); end
    end
    tick();
    total++; if (status() !== 8'b001_100_00 || bus.dwell !== 8'd0 || bus.attempts !== 4'd1) begin bad++; $display("FAIL yellow_back got=%b/%0d/%0d exp=%b/0/1", status(), bus.dwell, bus.attempts, 8'b001_100_00); end
    bus.a1 = 1'b0;
    tick();
  endtask

  task automatic test_cheat_recovery();
    bus.cheat_out = 1'b1;
    tick();
    total++; if (status() !== 8'b011_001_00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL cheat_red got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b011_001_00); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (status() !== 8'b011_001_00 || bus.dwell !== 8'(i)) begin bad++; $display("FAIL cheat_hold%0d got=%b/%0d exp=%b/%0d", i, status(), bus.dwell, 8'b011_001_00, i); end
    end
    bus.cheat_out = 1'b0;
    tick();
    total++; if (status() !== 8'b001_100_00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL cheat_recover got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b001_100_00); end
  endtask

  task automatic test_a2_red();
    bus.a2 = 1'b1;
    tick();
    total++; if (status() !== 8'b011_001_00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL a2_red got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b011_001_00); end
    repeat (2) tick();
    bus.a2 = 1'b0;
    tick();
    total++; if (status() !== 8'b001_100_00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL a2_fall got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b001_100_00); end
    bus.a2 = 1'b1;
    repeat (3) tick();
    total++; if (status() !== 8'b011_001_00 || bus.dwell !== 8'd2) begin bad++; $display("FAIL a2_dwell got=%b/%0d exp=%b/2", status(), bus.dwell, 8'b011_001_00); end
    bus.cheat_out = 1'b1;
    tick();
    total++; if (status() !== 8'b011_001_00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL cheat_restart got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b011_001_00); end
    bus.cheat_out = 1'b0;
    tick();
    total++; if (status() !== 8'b001_100_00) begin bad++; $display("FAIL restart_mode got=%b exp=%b", status(), 8'b001_100_00); end
    bus.a2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_red();
    bus.cheat_out = 1'b1;
    repeat (8) tick();
    total++; if (status() !== 8'b011_001_00 || bus.dwell !== 8'd7) begin bad++; $display("FAIL red_dwell7 got=%b/%0d exp=%b/7", status(), bus.dwell, 8'b011_001_00); end
    reset_n = 1'b0;
    tick();
    total++; if (status() !== 8'h00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL mid_red_reset got=%b/%0d exp=%b/0", status(), bus.dwell, 8'h00); end
    reset_n = 1'b1;
    bus.cheat_out = 1'b0;
    tick();
    total++; if (status() !== 8'b001_100_00 || bus.dwell !== 8'd0) begin bad++; $display("FAIL reenable got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b001_100_00); end
  endtask

  task automatic test_lockdown();
    bus.cheat_out = 1'b1;
    tick();
    for (int i = 1; i <= 14; i++) begin
      tick();
      total++; if (status() !== 8'b011_001_00) begin bad++; $display("FAIL lock_red%0d got=%b exp=%b", i, status(), 8'b011_001_00); end
    end
    tick();
    total++; if (status() !== 8'b100_000_10 || bus.dwell !== 8'd0) begin bad++; $display("FAIL lock_enter got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b100_000_10); end
    set_inputs(0, 1, 1, 1, 0);
    repeat (3) tick();
    bus.a1 = 1'b0;
    repeat (2) tick();
    total++; if (status() !== 8'b100_000_10) begin bad++; $display("FAIL lock_terminal got=%b exp=%b", status(), 8'b100_000_10); end
  endtask

  task automatic test_breach();
    reset_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    bus.enable = 1'b1;
    tick();
    set_inputs(1, 0, 1, 1, 1);
    tick();
    total++; if (status() !== 8'b101_000_01 || bus.dwell !== 8'd0) begin bad++; $display("FAIL breach_enter got=%b/%0d exp=%b/0", status(), bus.dwell, 8'b101_000_01); end
    for (int i = 0; i < 10; i++) begin
      bus.a1 = 1'b1; tick();
      bus.a1 = 1'b0; tick();
    end
    total++; if (bus.attempts !== 4'd10 || bus.dwell !== 8'd20) begin bad++; $display("FAIL attempts10 got=%0d/%0d exp=10/20", bus.attempts, bus.dwell); end
    for (int i = 0; i < 10; i++) begin
      bus.a1 = 1'b1; tick();
      bus.a1 = 1'b0; tick();
    end
    total++; if (bus.attempts !== 4'd15) begin bad++; $display("FAIL attempts_sat got=%0d exp=15", bus.attempts); end
    repeat (214) tick();
    total++; if (bus.dwell !== 8'd254) begin bad++; $display("FAIL dwell254 got=%0d exp=254", bus.dwell); end
    repeat (45) tick();
    total++; if (status() !== 8'b101_000_01 || bus.dwell !== 8'd255) begin bad++; $display("FAIL breach_sat got=%b/%0d exp=%b/255", status(), bus.dwell, 8'b101_000_01); end
  endtask

  initial begin
    reset_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    test_reset();
    test_yellow();
    test_cheat_recovery();
    test_a2_red();
    test_reset_mid_red();
    test_lockdown();
    test_breach();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
